// File: rtl/tk_line_fetch.sv
// tk_line_fetch: fetches an aligned 8-word line for the wrapper over a
// single-word memory port, with an outstanding-read limit and finish drain.
module tk_line_fetch #(
  parameter logic [31:0] BASE_OFFSET     = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] rd_addr,
  input  logic        finish,
  output logic [31:0] data_0,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [31:0] data_3,
  output logic [31:0] data_4,
  output logic [31:0] data_5,
  output logic [31:0] data_6,
  output logic [31:0] data_7,
  output logic [1:0]  host_sig,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        done,
  output logic [15:0] fetch_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  logic [2:0]  state;
  logic [26:0] tag;
  logic [3:0]  iss;
  logic [3:0]  rsp;
  logic [3:0]  iss_n;
  logic [3:0]  rsp_n;
  logic        acc;
  logic        take;
  logic [31:0] line_q [8];
  logic        unused_lo;

  // Line offset bits never matter: only the tag selects a line.
  assign unused_lo = ^rd_addr[4:0];

  assign mem_req  = (state == S_FETCH) && (iss < 4'd8)
                    && ((iss - rsp) < MAX_OS);
  assign mem_addr = {tag, 5'b0} + {26'b0, iss, 2'b0} + BASE_OFFSET;

  // A beat with nothing outstanding is spurious and dropped.
  assign acc   = mem_req & mem_ready;
  assign take  = mem_rvalid && (rsp != iss)
                 && ((state == S_FETCH) || (state == S_DRAIN));
  assign iss_n = iss + {3'b0, acc};
  assign rsp_n = rsp + {3'b0, take};

  assign data_0 = line_q[0];
  assign data_1 = line_q[1];
  assign data_2 = line_q[2];
  assign data_3 = line_q[3];
  assign data_4 = line_q[4];
  assign data_5 = line_q[5];
  assign data_6 = line_q[6];
  assign data_7 = line_q[7];

  // Line buffer: only beats taken while fetching land; drain beats vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) line_q[k] <= '0;
    end else if ((state == S_FETCH) && take) begin
      line_q[rsp[2:0]] <= mem_rdata;
    end
  end

  // Control FSM with issue/response counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tag         <= '0;
      iss         <= '0;
      rsp         <= '0;
      host_sig    <= 2'b00;
      done        <= 1'b0;
      fetch_count <= '0;
    end else begin
      iss <= iss_n;
      rsp <= rsp_n;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_FETCH;
            tag      <= rd_addr[31:5];
            iss      <= '0;
            rsp      <= '0;
            host_sig <= 2'b01;
            done     <= 1'b0;
          end
        end
        S_FETCH: begin
          if (finish) begin
            host_sig <= 2'b00;
            if (iss_n == rsp_n) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (rsp_n == 4'd8) begin
            state    <= S_VALID;
            host_sig <= 2'b11;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        S_VALID: begin
          if (finish) begin
            state    <= S_DONE;
            done     <= 1'b1;
            host_sig <= 2'b00;
          end else if (rd_addr[31:5] != tag) begin
            state    <= S_FETCH;
            tag      <= rd_addr[31:5];
            iss      <= '0;
            rsp      <= '0;
            host_sig <= 2'b01;
          end
        end
        S_DRAIN: begin
          if (iss_n == rsp_n) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          host_sig <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tk_line_fetch.sv
// Directed bench for tk_line_fetch: two instances (default limit, and
// limit 2 with a base offset), each with its own latency memory model.
module tb_tk_line_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: defaults ----------------
  logic        start_a, finish_a, ready_a;
  logic [31:0] rd_addr_a;
  logic [31:0] da [8];
  logic [1:0]  hs_a;
  logic        req_a, rvalid_a, done_a;
  logic [31:0] addr_a, rdata_a;
  logic [15:0] fc_a;
  int          lat_a;
  logic        mv_a = 1'b0;
  logic [31:0] md_a = '0;
  logic        inj_v;
  logic [31:0] inj_d;
  logic [31:0] qa_a [$];
  int          qd_a [$];
  logic [31:0] log_a [$];
  int          acc_a = 0;
  int          rc_a = 0;

  assign rvalid_a = mv_a | inj_v;
  assign rdata_a  = inj_v ? inj_d : md_a;

  tk_line_fetch u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rd_addr(rd_addr_a),
    .finish(finish_a),
    .data_0(da[0]), .data_1(da[1]), .data_2(da[2]), .data_3(da[3]),
    .data_4(da[4]), .data_5(da[5]), .data_6(da[6]), .data_7(da[7]),
    .host_sig(hs_a), .mem_req(req_a), .mem_addr(addr_a),
    .mem_ready(ready_a), .mem_rdata(rdata_a), .mem_rvalid(rvalid_a),
    .done(done_a), .fetch_count(fc_a)
  );

  // Memory A: word value = byte address, fixed latency, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_a.delete();
      qd_a.delete();
      mv_a <= 1'b0;
    end else begin
      if (mv_a) rc_a <= rc_a + 1;
      if (req_a && ready_a) begin
        qa_a.push_back(addr_a);
        qd_a.push_back(cyc + lat_a);
        log_a.push_back(addr_a);
        acc_a <= acc_a + 1;
      end
      if (qd_a.size() > 0 && qd_a[0] <= cyc + 1) begin
        mv_a <= 1'b1;
        md_a <= qa_a[0];
        void'(qa_a.pop_front());
        void'(qd_a.pop_front());
      end else begin
        mv_a <= 1'b0;
      end
    end
  end

  // ---------------- instance B: limit 2, offset 0x1000 ----------------
  logic        start_b, finish_b, ready_b;
  logic [31:0] rd_addr_b;
  logic [31:0] db [8];
  logic [1:0]  hs_b;
  logic        req_b, done_b;
  logic [31:0] addr_b;
  logic [15:0] fc_b;
  int          lat_b;
  logic        mv_b = 1'b0;
  logic [31:0] md_b = '0;
  logic [31:0] qa_b [$];
  int          qd_b [$];
  int          acc_b = 0;
  int          rc_b = 0;

  tk_line_fetch #(.BASE_OFFSET(32'h0000_1000), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rd_addr(rd_addr_b),
    .finish(finish_b),
    .data_0(db[0]), .data_1(db[1]), .data_2(db[2]), .data_3(db[3]),
    .data_4(db[4]), .data_5(db[5]), .data_6(db[6]), .data_7(db[7]),
    .host_sig(hs_b), .mem_req(req_b), .mem_addr(addr_b),
    .mem_ready(ready_b), .mem_rdata(md_b), .mem_rvalid(mv_b),
    .done(done_b), .fetch_count(fc_b)
  );

  // Memory B: same behaviour as memory A.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_b.delete();
      qd_b.delete();
      mv_b <= 1'b0;
    end else begin
      if (mv_b) rc_b <= rc_b + 1;
      if (req_b && ready_b) begin
        qa_b.push_back(addr_b);
        qd_b.push_back(cyc + lat_b);
        acc_b <= acc_b + 1;
      end
      if (qd_b.size() > 0 && qd_b[0] <= cyc + 1) begin
        mv_b <= 1'b1;
        md_b <= qa_b[0];
        void'(qa_b.pop_front());
        void'(qd_b.pop_front());
      end else begin
        mv_b <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int acc0, rc0, maxo, o;

  initial begin
    rst = 1'b1;
    start_a = 0; finish_a = 0; ready_a = 1; rd_addr_a = '0; lat_a = 1;
    start_b = 0; finish_b = 0; ready_b = 1; rd_addr_b = '0; lat_b = 4;
    inj_v = 0; inj_d = '0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_host_sig", hs_a, 2'b00);
    chk("rst_mem_req", req_a, 1'b0);
    chk("rst_mem_addr", addr_a, 32'h0);
    chk("rst_mem_addr_b", addr_b, 32'h1000);
    chk("rst_done", done_a, 1'b0);
    chk("rst_fetch_count", fc_a, 16'd0);
    chk("rst_data_0", da[0], 32'h0);
    chk("rst_data_7", da[7], 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // basic line fetch
    rd_addr_a = 32'h0000_0044;
    log_a.delete();
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("fetch_host_sig", hs_a, 2'b01);
    chk("fetch_mem_req", req_a, 1'b1);
    chk("fetch_first_addr", addr_a, 32'h40);
    repeat (8) @(negedge clk);
    chk("host_sig_at_9", hs_a, 2'b01);
    @(negedge clk);
    chk("host_sig_at_10", hs_a, 2'b11);
    chk("basic_req_count", log_a.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("basic_addr_%0d", k), log_a[k], 32'h40 + 4 * k);
      chk($sformatf("basic_data_%0d", k), da[k], 32'h40 + 4 * k);
    end
    chk("basic_fetch_count", fc_a, 16'd1);

    // line change while valid
    @(negedge clk);
    rd_addr_a = 32'h0000_0120;
    log_a.delete();
    @(negedge clk);
    chk("chg_host_sig", hs_a, 2'b01);
    chk("chg_mem_req", req_a, 1'b1);
    chk("chg_first_addr", addr_a, 32'h120);
    for (int i = 0; i < 30 && hs_a !== 2'b11; i++) @(negedge clk);
    chk("chg_valid", hs_a, 2'b11);
    chk("chg_req_count", log_a.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("chg_addr_%0d", k), log_a[k], 32'h120 + 4 * k);
      chk($sformatf("chg_data_%0d", k), da[k], 32'h120 + 4 * k);
    end
    chk("chg_fetch_count", fc_a, 16'd2);

    // backpressure, limit 2, latency 4, offset 0x1000
    rd_addr_b = 32'h0000_0204;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    maxo = 0;
    for (int i = 0; i < 200 && hs_b !== 2'b11; i++) begin
      @(negedge clk);
      o = acc_b - rc_b;
      if (o > maxo) maxo = o;
      ready_b = ~ready_b;
    end
    chk("bp_valid", hs_b, 2'b11);
    chk("bp_max_outstanding", maxo, 2);
    for (int k = 0; k < 8; k++)
      chk($sformatf("bp_data_%0d", k), db[k], 32'h1200 + 4 * k);
    chk("bp_fetch_count", fc_b, 16'd1);
    ready_b = 1;

    // finish mid-fetch after 5 accepts and 2 responses
    lat_a = 4;
    acc0 = acc_a;
    rc0 = rc_a;
    rd_addr_a = 32'h0000_0300;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_a - acc0 >= 5) ready_a = 0;
      if (acc_a - acc0 >= 5 && rc_a - rc0 >= 2) break;
    end
    chk("fin_accepts", acc_a - acc0, 5);
    chk("fin_responses", rc_a - rc0, 2);
    finish_a = 1;
    @(negedge clk);
    finish_a = 0;
    chk("fin_host_sig", hs_a, 2'b00);
    chk("fin_mem_req", req_a, 1'b0);
    chk("fin_done_early", done_a, 1'b0);
    @(negedge clk);
    chk("fin_done_last_beat", done_a, 1'b0);
    @(negedge clk);
    chk("fin_done", done_a, 1'b1);
    chk("fin_beats_consumed", rc_a - rc0, 5);
    chk("fin_data_2", da[2], 32'h308);
    chk("fin_data_3_kept", da[3], 32'h12C);
    chk("fin_fetch_count", fc_a, 16'd2);
    ready_a = 1;
    lat_a = 1;

    // start in DONE, then reset mid-fetch
    rd_addr_a = 32'h0000_0400;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("restart_done_cleared", done_a, 1'b0);
    chk("restart_host_sig", hs_a, 2'b01);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_host_sig", hs_a, 2'b00);
    chk("arst_mem_req", req_a, 1'b0);
    chk("arst_mem_addr", addr_a, 32'h0);
    chk("arst_fetch_count", fc_a, 16'd0);
    chk("arst_data_0", da[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inj_d = 32'hDEAD_BEEF;
    inj_v = 1;
    @(negedge clk);
    inj_v = 0;
    chk("stale_idle_host_sig", hs_a, 2'b00);
    chk("stale_idle_data_0", da[0], 32'h0);
    log_a.delete();
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    inj_v = 1;
    @(negedge clk);
    inj_v = 0;
    for (int i = 0; i < 30 && hs_a !== 2'b11; i++) @(negedge clk);
    chk("rs_valid", hs_a, 2'b11);
    chk("rs_data_0", da[0], 32'h400);
    chk("rs_data_7", da[7], 32'h41C);
    chk("rs_fetch_count", fc_a, 16'd1);

    // finish in VALID with nothing outstanding, then start from DONE
    finish_a = 1;
    @(negedge clk);
    finish_a = 0;
    chk("vfin_done", done_a, 1'b1);
    chk("vfin_host_sig", hs_a, 2'b00);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("done_start_done", done_a, 1'b0);
    chk("done_start_host_sig", hs_a, 2'b01);
    for (int i = 0; i < 30 && hs_a !== 2'b11; i++) @(negedge clk);
    chk("done_start_valid", hs_a, 2'b11);
    chk("done_start_fetch_count", fc_a, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
